// File: rtl/keypad_pkg.sv
// -----------------------------------------------------------------------------
// keypad_pkg
// Shared types and constants for the 4x4 matrix keypad scanner.
//   kp_state_e          : debounce FSM states
//   kp_res_e            : per-scan result encoding (NONE / KEY / MULTI)
//   KEYMAP              : hex code of each key, indexed {col_idx, row_idx}
//   KP_SCAN_CYCLES_DEF  : default clocks per column (0.25 ms at 50 MHz)
// -----------------------------------------------------------------------------
package keypad_pkg;

  localparam int KP_SCAN_CYCLES_DEF = 12500;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_PRESSED  = 2'd2,
    ST_RELEASE  = 2'd3
  } kp_state_e;

  typedef enum logic [1:0] {
    RES_NONE  = 2'd0,
    RES_KEY   = 2'd1,
    RES_MULTI = 2'd2
  } kp_res_e;

  // Four entries per column, rows 0..3 in order.
  localparam logic [3:0] KEYMAP [16] = '{
    4'h1, 4'h4, 4'h7, 4'h0,   // col0
    4'h2, 4'h5, 4'h8, 4'hF,   // col1
    4'h3, 4'h6, 4'h9, 4'hE,   // col2
    4'hA, 4'hB, 4'hC, 4'hD    // col3
  };

  function automatic logic [3:0] kp_lookup(input logic [1:0] col_idx,
                                           input logic [1:0] row_idx);
    return KEYMAP[{col_idx, row_idx}];
  endfunction

endpackage

// File: rtl/keypad_debounce.sv
// -----------------------------------------------------------------------------
// keypad_debounce
// Debounce FSM evaluated once per full-scan result. A key is accepted after
// DEBOUNCE_SCANS consecutive identical KEY scans and released after
// DEBOUNCE_SCANS consecutive NONE scans. MULTI is treated as NONE.
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   i_scan_vld    : one-cycle strobe, a full-scan result is present
//   i_scan_res    : scan result (kp_res_e encoding)
//   i_scan_key    : key code when i_scan_res == RES_KEY
//   o_accept      : one-cycle accept strobe, coincident with i_scan_vld
//                   (i_scan_key equals the accepted candidate at that moment)
//   o_key_held    : registered, high in PRESSED and RELEASE
// -----------------------------------------------------------------------------
module keypad_debounce
  import keypad_pkg::*;
#(
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_scan_vld,
  input  logic [1:0] i_scan_res,
  input  logic [3:0] i_scan_key,
  output logic       o_accept,
  output logic       o_key_held
);

  localparam int DW = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [DW-1:0] DS_MAX = DW'(DEBOUNCE_SCANS);

  kp_state_e     r_state, w_state_nxt;
  logic [DW-1:0] r_dcnt, w_dcnt_nxt;
  logic [3:0]    r_cand, w_cand_nxt;
  logic          r_key_held;
  logic          w_accept;
  logic          w_is_key;

  assign w_is_key = (i_scan_res == RES_KEY);

  // NOTE: every variable written here gets a default first, so no path
  // through the case leaves it unassigned and no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    w_dcnt_nxt  = r_dcnt;
    w_cand_nxt  = r_cand;
    w_accept    = 1'b0;
    if (i_scan_vld) begin
      case (r_state)
        ST_IDLE: begin
          if (w_is_key) begin
            w_cand_nxt = i_scan_key;
            w_dcnt_nxt = DW'(1);
            if (DEBOUNCE_SCANS == 1) begin
              w_state_nxt = ST_PRESSED;
              w_accept    = 1'b1;
            end else begin
              w_state_nxt = ST_DEBOUNCE;
            end
          end
        end
        ST_DEBOUNCE: begin
          if (!w_is_key) begin
            w_state_nxt = ST_IDLE;
          end else if (i_scan_key != r_cand) begin
            w_cand_nxt = i_scan_key;
            w_dcnt_nxt = DW'(1);
          end else if (r_dcnt + DW'(1) == DS_MAX) begin
            w_dcnt_nxt  = DS_MAX;
            w_state_nxt = ST_PRESSED;
            w_accept    = 1'b1;
          end else begin
            w_dcnt_nxt = r_dcnt + DW'(1);
          end
        end
        ST_PRESSED: begin
          // Any key (even a different one) keeps us here until a full release.
          if (!w_is_key) begin
            w_dcnt_nxt  = DW'(1);
            w_state_nxt = (DEBOUNCE_SCANS == 1) ? ST_IDLE : ST_RELEASE;
          end
        end
        ST_RELEASE: begin
          if (w_is_key) begin
            w_state_nxt = ST_PRESSED;
          end else if (r_dcnt + DW'(1) == DS_MAX) begin
            w_dcnt_nxt  = DS_MAX;
            w_state_nxt = ST_IDLE;
          end else begin
            w_dcnt_nxt = r_dcnt + DW'(1);
          end
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of every other register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_dcnt     <= '0;
      r_cand     <= '0;
      r_key_held <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_dcnt     <= w_dcnt_nxt;
      r_cand     <= w_cand_nxt;
      r_key_held <= (w_state_nxt == ST_PRESSED) || (w_state_nxt == ST_RELEASE);
    end
  end

  assign o_accept   = w_accept;
  assign o_key_held = r_key_held;

endmodule

// File: rtl/keypad_scan.sv
// -----------------------------------------------------------------------------
// keypad_scan
// 4x4 matrix keypad scanner: drives one active-low column at a time, samples
// the synchronized active-low rows at the end of each column slot, classifies
// each full scan (NONE / KEY / MULTI) and debounces it in keypad_debounce.
// Each accepted press updates key_code, pulses key_valid and shifts the key
// into data_out (newest in [3:0]).
// Build option: define KEYPAD_CLEAR_EN to make key C clear data_out instead
// of shifting in.
// Ports:
//   clk, rst   : 50 MHz clock, synchronous active-high reset
//   row[3:0]   : keypad rows, active-low, asynchronous
//   col[3:0]   : keypad columns, active-low, one-hot-low while scanning
//   key_code   : hex code of the last accepted key
//   key_valid  : one-cycle strobe per accepted press
//   key_held   : high while the accepted key is considered down
//   data_out   : last four keys, feeds the seven-segment driver
// -----------------------------------------------------------------------------
module keypad_scan
  import keypad_pkg::*;
#(
  parameter int SCAN_CYCLES    = KP_SCAN_CYCLES_DEF,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  row,
  output logic [3:0]  col,
  output logic [3:0]  key_code,
  output logic        key_valid,
  output logic        key_held,
  output logic [15:0] data_out
);

  localparam int CW = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_CYCLES - 1);

  logic [3:0]    r_row_s1, r_row_s2;
  logic [CW-1:0] r_cnt;
  logic [1:0]    r_col_idx;
  logic [3:0]    r_col;
  logic [1:0]    r_acc_hits;   // saturates at 2 (= MULTI)
  logic [3:0]    r_acc_key;
  logic          r_scan_vld;
  logic [1:0]    r_scan_res;
  logic [3:0]    r_scan_key;
  logic [3:0]    r_key_code;
  logic          r_key_valid;
  logic [15:0]   r_data;

  logic          w_cnt_wrap;
  logic [1:0]    w_col_idx_nxt;
  logic [2:0]    w_col_hits;
  logic [1:0]    w_row_idx;
  logic [2:0]    w_acc_sum;
  logic [1:0]    w_acc_hits;
  logic [3:0]    w_acc_key;
  kp_res_e       w_res;
  logic          w_accept;
  logic          w_key_held;

  assign w_cnt_wrap    = (r_cnt == CNT_LAST);
  assign w_col_idx_nxt = w_cnt_wrap ? r_col_idx + 2'd1 : r_col_idx;

  // Count low rows in the current column; the lowest low row wins the index
  // (only meaningful when exactly one hit survives the whole scan).
  always_comb begin
    w_col_hits = '0;
    w_row_idx  = '0;
    for (int r = 3; r >= 0; r--) begin
      if (!r_row_s2[r]) begin
        w_col_hits = w_col_hits + 3'd1;
        w_row_idx  = 2'(r);
      end
    end
  end

  // Column 0 starts a fresh scan, so prior accumulation is discarded there.
  always_comb begin
    w_acc_sum  = ((r_col_idx == 2'd0) ? 3'd0 : {1'b0, r_acc_hits}) + w_col_hits;
    w_acc_hits = (w_acc_sum >= 3'd2) ? 2'd2 : w_acc_sum[1:0];
    if (w_col_hits != 3'd0)
      w_acc_key = kp_lookup(r_col_idx, w_row_idx);
    else if (r_col_idx == 2'd0)
      w_acc_key = 4'h0;
    else
      w_acc_key = r_acc_key;
    case (w_acc_hits)
      2'd0:    w_res = RES_NONE;
      2'd1:    w_res = RES_KEY;
      default: w_res = RES_MULTI;
    endcase
  end

  // NOTE: synchronous reset also covers the synchronizer, loading idle-high
  // rows so the first scan after reset starts from a released keypad.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_row_s1    <= 4'hF;
      r_row_s2    <= 4'hF;
      r_cnt       <= '0;
      r_col_idx   <= '0;
      r_col       <= 4'hF;
      r_acc_hits  <= '0;
      r_acc_key   <= '0;
      r_scan_vld  <= 1'b0;
      r_scan_res  <= RES_NONE;
      r_scan_key  <= '0;
      r_key_code  <= '0;
      r_key_valid <= 1'b0;
      r_data      <= '0;
    end else begin
      r_row_s1    <= row;
      r_row_s2    <= r_row_s1;
      r_cnt       <= w_cnt_wrap ? '0 : r_cnt + CW'(1);
      r_col_idx   <= w_col_idx_nxt;
      r_col       <= ~(4'b0001 << w_col_idx_nxt);
      r_scan_vld  <= 1'b0;
      if (w_cnt_wrap) begin
        r_acc_hits <= w_acc_hits;
        r_acc_key  <= w_acc_key;
        if (r_col_idx == 2'd3) begin
          r_scan_vld <= 1'b1;
          r_scan_res <= w_res;
          r_scan_key <= w_acc_key;
        end
      end
      // On accept the scan key equals the debounced candidate.
      r_key_valid <= w_accept;
      if (w_accept) begin
        r_key_code <= r_scan_key;
`ifdef KEYPAD_CLEAR_EN
        if (r_scan_key == 4'hC)
          r_data <= 16'h0000;
        else
          r_data <= {r_data[11:0], r_scan_key};
`else
        r_data <= {r_data[11:0], r_scan_key};
`endif
      end
    end
  end

  keypad_debounce #(
    .DEBOUNCE_SCANS(DEBOUNCE_SCANS)
  ) u_debounce (
    .clk        (clk),
    .rst        (rst),
    .i_scan_vld (r_scan_vld),
    .i_scan_res (r_scan_res),
    .i_scan_key (r_scan_key),
    .o_accept   (w_accept),
    .o_key_held (w_key_held)
  );

  assign col       = r_col;
  assign key_code  = r_key_code;
  assign key_valid = r_key_valid;
  assign key_held  = w_key_held;
  assign data_out  = r_data;

endmodule
